// File: rtl/mem_pkg.sv
`default_nettype none
// mem_pkg -- memory-op encodings and load-metadata record shared by the load aligner (rev 1.0)
package mem_pkg;

  localparam logic [1:0] MEMOP_NONE  = 2'b00;
  localparam logic [1:0] MEMOP_LOAD  = 2'b01;
  localparam logic [1:0] MEMOP_STORE = 2'b10;

  localparam logic [1:0] MEMSIZE_B = 2'b00;
  localparam logic [1:0] MEMSIZE_H = 2'b01;
  localparam logic [1:0] MEMSIZE_W = 2'b10;
  localparam logic [1:0] MEMSIZE_D = 2'b11;

  // off is sized for the widest datapath; on XLEN=32 bit 2 is always zero
  typedef struct packed {
    logic [2:0] off;
    logic [1:0] size;
    logic       uns;
    logic [4:0] rd;
    logic       mis;
  } meta_t;

  function automatic int meta_width();
    return $bits(meta_t);
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off,
                                         input logic narrow);
    logic m;
    m = 1'b0;
    case (size)
      MEMSIZE_H: m = off[0];
      MEMSIZE_W: m = (off[1:0] != 2'b00);
      MEMSIZE_D: m = narrow || (off != 3'b000);
      default:   m = 1'b0;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_load_extract.sv
`default_nettype none
// mem_load_extract -- shifts the addressed field down, truncates and sign/zero-extends (rev 1.0)
module mem_load_extract
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] raw,
  input  logic [2:0]      off,
  input  logic [1:0]      size,
  input  logic            uns,
  input  logic            mis,
  output logic [XLEN-1:0] data
);

  localparam logic [XLEN-1:0] MASK_B = XLEN'(8'hFF);
  localparam logic [XLEN-1:0] MASK_H = XLEN'(16'hFFFF);
  localparam logic [XLEN-1:0] MASK_W = XLEN'(32'hFFFF_FFFF);

  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] mask;
  logic            sign;

  always_comb begin
    shifted = raw >> {off, 3'b000};
    mask    = '1;
    sign    = shifted[XLEN-1];
    case (size)
      MEMSIZE_B: begin mask = MASK_B; sign = shifted[7];  end
      MEMSIZE_H: begin mask = MASK_H; sign = shifted[15]; end
      MEMSIZE_W: begin mask = MASK_W; sign = shifted[31]; end
      default:   ;
    endcase
    data = '0;
    if (!mis) data = (shifted & mask) | ({XLEN{sign & ~uns}} & ~mask);
  end

endmodule
`default_nettype wire

// File: rtl/mem_load_align.sv
`default_nettype none
// mem_load_align -- in-order load-return aligner with credit-based request flow control (rev 1.0)
module mem_load_align
  import mem_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            reqValid,
  output logic            reqReady,
  input  logic [XLEN-1:0] reqAddr,
  input  logic [1:0]      reqMemOp,
  input  logic [1:0]      reqMemSize,
  input  logic            reqUnsigned,
  input  logic [4:0]      reqRd,
  input  logic            memRspValid,
  input  logic [XLEN-1:0] memRspData,
  output logic            outValid,
  input  logic            outReady,
  output logic [XLEN-1:0] outData,
  output logic [4:0]      outRd,
  output logic            outMisaligned,
  output logic            errUnexpected
);

  localparam int OFFW   = $clog2(XLEN/8);
  localparam int PTRW   = $clog2(DEPTH);
  localparam int CNTW   = $clog2(DEPTH+1);
  localparam int META_W = meta_width();
  localparam logic [CNTW-1:0] FULL_CREDITS = CNTW'(DEPTH);

  logic [META_W-1:0] meta_mem [DEPTH];
  logic [PTRW-1:0]   meta_wr, meta_rd;
  logic [CNTW-1:0]   meta_cnt;

  logic [XLEN-1:0]   res_data [DEPTH];
  logic [4:0]        res_tag  [DEPTH];
  logic [DEPTH-1:0]  res_mis;
  logic [PTRW-1:0]   res_wr, res_rd;
  logic [CNTW-1:0]   res_cnt;

  logic [CNTW-1:0]   credits, drop_cnt, drop_flush;
  logic              err;

  meta_t             new_meta, head_meta;
  logic [XLEN-1:0]   head_data;
  logic              load_acc, rsp_pop, rsp_drop, rsp_orphan, retire;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^reqAddr[XLEN-1:OFFW];

  always_comb begin
    new_meta      = '0;
    new_meta.off  = 3'(reqAddr[OFFW-1:0]);
    new_meta.size = reqMemSize;
    new_meta.uns  = reqUnsigned;
    new_meta.rd   = reqRd;
    new_meta.mis  = is_misaligned(reqMemSize, new_meta.off, XLEN == 32);
  end

  assign head_meta = meta_t'(meta_mem[meta_rd]);

  mem_load_extract #(.XLEN(XLEN)) u_extract (
    .raw  (memRspData),
    .off  (head_meta.off),
    .size (head_meta.size),
    .uns  (head_meta.uns),
    .mis  (head_meta.mis),
    .data (head_data)
  );

  assign reqReady   = rst_n && !flush && (credits != '0) && (drop_cnt == '0);
  assign load_acc   = reqValid && reqReady && (reqMemOp == MEMOP_LOAD);
  assign rsp_drop   = memRspValid && (drop_cnt != '0);
  assign rsp_pop    = memRspValid && (drop_cnt == '0) && (meta_cnt != '0);
  assign rsp_orphan = memRspValid && (drop_cnt == '0) && (meta_cnt == '0);
  assign retire     = outValid && outReady;

  // A response arriving in the flush cycle belongs to the oldest pending load and is dropped with it
  assign drop_flush = drop_cnt + meta_cnt - CNTW'(rsp_drop | rsp_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_wr  <= '0;
      meta_rd  <= '0;
      meta_cnt <= '0;
      res_wr   <= '0;
      res_rd   <= '0;
      res_cnt  <= '0;
      credits  <= FULL_CREDITS;
      drop_cnt <= '0;
      err      <= 1'b0;
    end else if (flush) begin
      meta_wr  <= '0;
      meta_rd  <= '0;
      meta_cnt <= '0;
      res_wr   <= '0;
      res_rd   <= '0;
      res_cnt  <= '0;
      drop_cnt <= drop_flush;
      credits  <= FULL_CREDITS - drop_flush;
    end else begin
      if (load_acc) begin
        meta_mem[meta_wr] <= new_meta;
        meta_wr           <= meta_wr + 1'b1;
      end
      if (rsp_pop) begin
        meta_rd          <= meta_rd + 1'b1;
        res_data[res_wr] <= head_data;
        res_tag[res_wr]  <= head_meta.rd;
        res_mis[res_wr]  <= head_meta.mis;
        res_wr           <= res_wr + 1'b1;
      end
      if (retire) res_rd <= res_rd + 1'b1;
      meta_cnt <= meta_cnt + CNTW'(load_acc) - CNTW'(rsp_pop);
      res_cnt  <= res_cnt + CNTW'(rsp_pop) - CNTW'(retire);
      credits  <= credits + CNTW'(retire) + CNTW'(rsp_drop) - CNTW'(load_acc);
      if (rsp_drop)   drop_cnt <= drop_cnt - 1'b1;
      if (rsp_orphan) err      <= 1'b1;
    end
  end

  assign outValid      = (res_cnt != '0);
  assign outData       = outValid ? res_data[res_rd] : '0;
  assign outRd         = outValid ? res_tag[res_rd]  : '0;
  assign outMisaligned = outValid && res_mis[res_rd];
  assign errUnexpected = err;

endmodule
`default_nettype wire

// File: tb/tb_mem_load_align.sv
`timescale 1ns/1ps
`default_nettype none
// tb_mem_load_align -- scoreboard bench for the 32- and 64-bit load aligner (rev 1.0)
module tb_mem_load_align;
  import mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [63:0] req_addr, rsp_data;
  logic [1:0]  req_op, req_size;
  logic        req_uns;
  logic [4:0]  req_rd;
  logic        req_valid32, req_valid64, rsp_valid32, rsp_valid64;
  logic        flush32, flush64, out_ready32, out_ready64;
  logic        req_ready32, req_ready64, out_valid32, out_valid64;
  logic        out_mis32, out_mis64, err32, err64;
  logic [31:0] out_data32;
  logic [63:0] out_data64;
  logic [4:0]  out_rd32, out_rd64;

  mem_load_align #(.XLEN(32), .DEPTH(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush32),
    .reqValid(req_valid32), .reqReady(req_ready32), .reqAddr(req_addr[31:0]),
    .reqMemOp(req_op), .reqMemSize(req_size), .reqUnsigned(req_uns), .reqRd(req_rd),
    .memRspValid(rsp_valid32), .memRspData(rsp_data[31:0]),
    .outValid(out_valid32), .outReady(out_ready32), .outData(out_data32), .outRd(out_rd32),
    .outMisaligned(out_mis32), .errUnexpected(err32)
  );

  mem_load_align #(.XLEN(64), .DEPTH(4)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush64),
    .reqValid(req_valid64), .reqReady(req_ready64), .reqAddr(req_addr),
    .reqMemOp(req_op), .reqMemSize(req_size), .reqUnsigned(req_uns), .reqRd(req_rd),
    .memRspValid(rsp_valid64), .memRspData(rsp_data),
    .outValid(out_valid64), .outReady(out_ready64), .outData(out_data64), .outRd(out_rd64),
    .outMisaligned(out_mis64), .errUnexpected(err64)
  );

  typedef struct {
    logic [63:0] data;
    logic [4:0]  rd;
    logic        mis;
  } exp_t;

  exp_t       sb32[$], sb64[$];
  logic [4:0] pend32[$], pend64[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Reference: byte-by-byte gather, then extension; result bit 64 is the misaligned flag
  function automatic logic [64:0] model(input logic [63:0] raw, input logic [63:0] addr,
                                        input logic [1:0] size, input logic uns, input int xlen);
    int          nbytes, off;
    logic [63:0] v;
    nbytes = 1 << size;
    off    = int'(addr[2:0]) % (xlen / 8);
    v      = '0;
    if ((off % nbytes) != 0 || nbytes * 8 > xlen) return {1'b1, 64'd0};
    for (int i = 0; i < nbytes * 8; i++) v[i] = raw[off*8 + i];
    for (int i = nbytes * 8; i < xlen; i++) v[i] = uns ? 1'b0 : raw[off*8 + nbytes*8 - 1];
    return {1'b0, v};
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid32 && out_ready32 && !flush32) begin
      if (sb32.size() == 0) check("out32_extra", 64'(sb32.size()), 64'd1);
      else begin
        exp_t e;
        e = sb32.pop_front();
        check("out32_data", 64'(out_data32), e.data);
        check("out32_rd",   64'(out_rd32),   64'(e.rd));
        check("out32_mis",  64'(out_mis32),  64'(e.mis));
      end
    end
    if (rst_n && out_valid64 && out_ready64 && !flush64) begin
      if (sb64.size() == 0) check("out64_extra", 64'(sb64.size()), 64'd1);
      else begin
        exp_t e;
        e = sb64.pop_front();
        check("out64_data", out_data64,     e.data);
        check("out64_rd",   64'(out_rd64),  64'(e.rd));
        check("out64_mis",  64'(out_mis64), 64'(e.mis));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit w64, input logic [1:0] op, input logic [63:0] addr,
                       input logic [1:0] size, input logic uns, input logic [4:0] rd);
    int n = 0;
    req_op = op; req_addr = addr; req_size = size; req_uns = uns; req_rd = rd;
    if (w64) req_valid64 = 1'b1; else req_valid32 = 1'b1;
    while (!(w64 ? req_ready64 : req_ready32) && n < 50) begin
      step();
      n++;
    end
    if (!(w64 ? req_ready64 : req_ready32))
      check("req_timeout", 64'(w64 ? req_ready64 : req_ready32), 64'd1);
    else if (op == MEMOP_LOAD) begin
      if (w64) pend64.push_back(rd); else pend32.push_back(rd);
    end
    step();
    req_valid32 = 1'b0;
    req_valid64 = 1'b0;
  endtask

  task automatic respond(input bit w64, input logic [63:0] raw, input logic [63:0] e_data,
                         input logic e_mis);
    exp_t e;
    rsp_data = raw;
    e.data   = e_data;
    e.mis    = e_mis;
    if (w64) begin
      if (pend64.size() != 0) begin e.rd = pend64.pop_front(); sb64.push_back(e); end
      rsp_valid64 = 1'b1;
    end else begin
      if (pend32.size() != 0) begin e.rd = pend32.pop_front(); sb32.push_back(e); end
      rsp_valid32 = 1'b1;
    end
    step();
    rsp_valid32 = 1'b0;
    rsp_valid64 = 1'b0;
  endtask

  task automatic fill_and_drain32(input logic [4:0] base);
    out_ready32 = 1'b0;
    for (int i = 0; i < 4; i++) issue(0, MEMOP_LOAD, 64'(i * 4), MEMSIZE_W, 1'b1, base + 5'(i));
    check("credits_out", 64'(req_ready32), 64'd0);
    for (int i = 0; i < 4; i++) respond(0, 64'(32'hA000_0000 + i), 64'(32'hA000_0000 + i), 1'b0);
    check("full_rdy", 64'(req_ready32), 64'd0);
    check("hold_valid", 64'(out_valid32), 64'd1);
    check("hold_rd", 64'(out_rd32), 64'(base));
    step();
    check("hold_rd2", 64'(out_rd32), 64'(base));
    out_ready32 = 1'b1;
    step();
    check("rdy_after_retire", 64'(req_ready32), 64'd1);
    repeat (4) step();
    check("drain_empty", 64'(out_valid32), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t        e;
    logic [64:0] m;
    logic [63:0] a, r;
    logic [1:0]  sz;
    logic        u;

    rst_n = 1'b0; flush32 = 1'b1; flush64 = 1'b0;
    req_valid32 = 1'b0; req_valid64 = 1'b0; rsp_valid32 = 1'b0; rsp_valid64 = 1'b0;
    out_ready32 = 1'b1; out_ready64 = 1'b1;
    req_addr = '0; rsp_data = '0; req_op = MEMOP_NONE; req_size = MEMSIZE_B; req_uns = 1'b0; req_rd = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy",   64'(req_ready32), 64'd0);
    check("rst_valid", 64'(out_valid32), 64'd0);
    check("rst_data",  64'(out_data32),  64'd0);
    check("rst_rd",    64'(out_rd32),    64'd0);
    check("rst_mis",   64'(out_mis32),   64'd0);
    check("rst_err",   64'(err32),       64'd0);
    check("rst_rdy64", 64'(req_ready64), 64'd0);
    flush32 = 1'b0;
    rst_n = 1'b1;
    step();
    check("rdy_after_rst", 64'(req_ready32), 64'd1);

    // lb sign-extension and one-cycle latency
    issue(0, MEMOP_LOAD, 64'h1003, MEMSIZE_B, 1'b0, 5'd5);
    respond(0, 64'h80FF_1234, 64'hFFFF_FF80, 1'b0);
    check("lat_valid", 64'(out_valid32), 64'd1);
    step();
    check("lat_drained", 64'(out_valid32), 64'd0);

    issue(0, MEMOP_LOAD, 64'h2002, MEMSIZE_H, 1'b1, 5'd6);
    respond(0, 64'hBEEF_0000, 64'h0000_BEEF, 1'b0);
    issue(0, MEMOP_LOAD, 64'h2001, MEMSIZE_W, 1'b0, 5'd7);
    respond(0, 64'h1234_5678, 64'd0, 1'b1);
    issue(0, MEMOP_LOAD, 64'h2000, MEMSIZE_D, 1'b0, 5'd8);
    respond(0, 64'h1234_5678, 64'd0, 1'b1);
    issue(0, MEMOP_LOAD, 64'h2002, MEMSIZE_H, 1'b0, 5'd9);
    respond(0, 64'h8001_0000, 64'hFFFF_8001, 1'b0);
    issue(0, MEMOP_LOAD, 64'h2001, MEMSIZE_B, 1'b1, 5'd10);
    respond(0, 64'h0000_F000, 64'h0000_00F0, 1'b0);
    issue(0, MEMOP_LOAD, 64'h2001, MEMSIZE_H, 1'b0, 5'd11);
    respond(0, 64'h1234_5678, 64'd0, 1'b1);

    for (int k = 0; k < 12; k++) begin
      a = 64'($urandom); r = {32'd0, $urandom}; sz = 2'($urandom_range(0, 3)); u = 1'($urandom);
      m = model(r, a, sz, u, 32);
      issue(0, MEMOP_LOAD, a, sz, u, 5'(k));
      respond(0, r, m[63:0], m[64]);
    end

    // load accept coinciding with the previous load's response
    issue(0, MEMOP_LOAD, 64'h3000, MEMSIZE_W, 1'b0, 5'd1);
    req_op = MEMOP_LOAD; req_addr = 64'h3002; req_size = MEMSIZE_H; req_uns = 1'b1; req_rd = 5'd2;
    req_valid32 = 1'b1; rsp_data = 64'h1122_3344; rsp_valid32 = 1'b1;
    check("overlap_rdy", 64'(req_ready32), 64'd1);
    e.rd = pend32.pop_front(); e.data = 64'h1122_3344; e.mis = 1'b0; sb32.push_back(e);
    step();
    req_valid32 = 1'b0; rsp_valid32 = 1'b0;
    pend32.push_back(5'd2);
    respond(0, 64'hAABB_0000, 64'h0000_AABB, 1'b0);
    step();

    fill_and_drain32(5'd12);

    // flush with two loads still outstanding
    issue(0, MEMOP_LOAD, 64'h0, MEMSIZE_W, 1'b0, 5'd20);
    issue(0, MEMOP_LOAD, 64'h4, MEMSIZE_W, 1'b0, 5'd21);
    issue(0, MEMOP_LOAD, 64'h8, MEMSIZE_W, 1'b0, 5'd22);
    respond(0, 64'h55, 64'h55, 1'b0);
    step();
    flush32 = 1'b1;
    step();
    flush32 = 1'b0;
    sb32.delete(); pend32.delete();
    check("flush_ovalid", 64'(out_valid32), 64'd0);
    check("drop_blocks", 64'(req_ready32), 64'd0);
    rsp_valid32 = 1'b1; step(); rsp_valid32 = 1'b0;
    check("drop1_blocks", 64'(req_ready32), 64'd0);
    check("drop1_noout", 64'(out_valid32), 64'd0);
    rsp_valid32 = 1'b1; step(); rsp_valid32 = 1'b0;
    check("drop2_ready", 64'(req_ready32), 64'd1);
    check("drop_noerr", 64'(err32), 64'd0);
    fill_and_drain32(5'd24);

    // unexpected response, then stores / no-ops consume no credit
    rsp_valid32 = 1'b1; step(); rsp_valid32 = 1'b0;
    check("err_set", 64'(err32), 64'd1);
    check("err_noout", 64'(out_valid32), 64'd0);
    repeat (3) step();
    check("err_sticky", 64'(err32), 64'd1);
    issue(0, MEMOP_STORE, 64'h40, MEMSIZE_W, 1'b0, 5'd3);
    issue(0, MEMOP_NONE,  64'h44, MEMSIZE_W, 1'b0, 5'd3);
    issue(0, 2'b11,       64'h48, MEMSIZE_W, 1'b0, 5'd3);
    step();
    check("store_noout", 64'(out_valid32), 64'd0);
    fill_and_drain32(5'd28);
    check("err_still", 64'(err32), 64'd1);

    // 64-bit datapath
    issue(1, MEMOP_LOAD, 64'h8, MEMSIZE_D, 1'b0, 5'd3);
    respond(1, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 1'b0);
    check("lat64_valid", 64'(out_valid64), 64'd1);
    issue(1, MEMOP_LOAD, 64'h4, MEMSIZE_W, 1'b0, 5'd4);
    respond(1, 64'hFFFF_FFFE_0000_0000, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    issue(1, MEMOP_LOAD, 64'h4, MEMSIZE_W, 1'b1, 5'd5);
    respond(1, 64'hFFFF_FFFE_0000_0000, 64'h0000_0000_FFFF_FFFE, 1'b0);
    issue(1, MEMOP_LOAD, 64'hC, MEMSIZE_D, 1'b0, 5'd6);
    respond(1, 64'h1234, 64'd0, 1'b1);
    issue(1, MEMOP_LOAD, 64'h7, MEMSIZE_B, 1'b0, 5'd7);
    respond(1, 64'h7F00_0000_0000_0000, 64'h7F, 1'b0);
    for (int k = 0; k < 8; k++) begin
      a = 64'($urandom); r = {$urandom, $urandom}; sz = 2'($urandom_range(0, 3)); u = 1'($urandom);
      m = model(r, a, sz, u, 64);
      issue(1, MEMOP_LOAD, a, sz, u, 5'(k + 8));
      respond(1, r, m[63:0], m[64]);
    end

    repeat (5) step();
    check("sb32_done", 64'(sb32.size()), 64'd0);
    check("sb64_done", 64'(sb64.size()), 64'd0);
    check("err64_clear", 64'(err64), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
